fpa_add_pipe: RTL



---
 rtl/fpa_add_pipe.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fpa_add_pipe.sv
// Parametrised IEEE-754 adder/subtractor: unpack/align, add/normalise, round/pack.
// Latency 4 register stages: an operand pair taken at edge N shows out_valid after edge N+3.
// Backpressure: the whole pipe freezes while out_valid && !out_ready; in_ready mirrors advance.
module fpa_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] number_A,
  input  logic [W-1:0] number_B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] number_out,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_inexact
);

  // significand with hidden bit plus guard/round/sticky
  localparam int SW = MAN_W + 4;
  // exponent / shift arithmetic width, wide enough for both
  localparam int XW = (EXP_W + 2 > $clog2(SW + 1) + 1) ? EXP_W + 2 : $clog2(SW + 1) + 1;
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- input capture ----------------
  logic         s0_vld;
  logic [W-1:0] s0_a, s0_b;

  // Capture operands; subtraction is folded into the sign of B here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld <= 1'b0;
      s0_a   <= '0;
      s0_b   <= '0;
    end else if (advance) begin
      s0_vld <= in_valid;
      s0_a   <= number_A;
      s0_b   <= {number_B[W-1] ^ op_sub, number_B[W-2:0]};
    end
  end

  // ---------------- S1: classify, swap, align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, inf_clash;

  assign {sa, ea, fa} = s0_a;
  assign {sb, eb, fb} = s0_b;
  assign a_nan     = (&ea) && (|fa);
  assign b_nan     = (&eb) && (|fb);
  assign a_inf     = (&ea) && !(|fa);
  assign b_inf     = (&eb) && !(|fb);
  assign a_snan    = a_nan && !fa[MAN_W-1];
  assign b_snan    = b_nan && !fb[MAN_W-1];
  assign inf_clash = a_inf && b_inf && (sa != sb);

  logic             swap, l_sign;
  logic [EXP_W-1:0] l_exp, s_exp;
  logic [MAN_W-1:0] l_frac, s_frac;
  logic [XW-1:0]    l_e, s_e, diff;
  logic [SW-1:0]    l_m, s_ext, s_sh, s_al;

  // Order by magnitude and right-align the smaller significand, folding lost bits into sticky.
  always_comb begin
    swap   = {eb, fb} > {ea, fa};
    l_sign = swap ? sb : sa;
    l_exp  = swap ? eb : ea;
    s_exp  = swap ? ea : eb;
    l_frac = swap ? fb : fa;
    s_frac = swap ? fa : fb;
    // subnormals share the exponent of the smallest normal
    l_e    = (l_exp == '0) ? XW'(1) : XW'(l_exp);
    s_e    = (s_exp == '0) ? XW'(1) : XW'(s_exp);
    l_m    = {(l_exp != '0), l_frac, 3'b000};
    s_ext  = {(s_exp != '0), s_frac, 3'b000};
    diff   = l_e - s_e;
    s_sh   = s_ext >> diff;
    if (diff >= XW'(MAN_W + 3)) s_al = {{(SW-1){1'b0}}, |s_ext};
    else                        s_al = {s_sh[SW-1:1], s_sh[0] | ((s_sh << diff) != s_ext)};
  end

  logic          s1_vld, s1_sign, s1_sub, s1_nan, s1_inv, s1_inf;
  logic [XW-1:0] s1_exp;
  logic [SW-1:0] s1_ml, s1_ms;

  // S1 register: aligned operands plus special-case decisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0;
      s1_nan <= 1'b0; s1_inv <= 1'b0; s1_inf <= 1'b0;
      s1_exp <= '0;   s1_ml <= '0;    s1_ms <= '0;
    end else if (advance) begin
      s1_vld  <= s0_vld;
      s1_sign <= l_sign;
      s1_sub  <= sa ^ sb;
      s1_nan  <= a_nan || b_nan || inf_clash;
      s1_inv  <= a_snan || b_snan || inf_clash;
      s1_inf  <= a_inf || b_inf;
      s1_exp  <= l_e;
      s1_ml   <= l_m;
      s1_ms   <= s_al;
    end
  end

  // ---------------- S2: add/sub, normalise ----------------
  logic [SW:0]   sum;
  logic [XW-1:0] lz, lim, shamt, n_e;
  logic [SW-1:0] n_m;
  logic          n_sign;

  // Effective add/sub, then normalise; left shift is clamped so the exponent never drops below 1.
  always_comb begin
    sum = s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});
    lz  = XW'(SW);
    for (int i = 0; i < SW; i++) if (sum[i]) lz = XW'(SW - 1 - i);
    lim   = s1_exp - XW'(1);
    shamt = (lz < lim) ? lz : lim;
    if (sum[SW]) begin
      n_m = {sum[SW:2], sum[1] | sum[0]};
      n_e = s1_exp + XW'(1);
    end else begin
      n_m = sum[SW-1:0] << shamt;
      n_e = s1_exp - shamt;
    end
    // exact cancellation yields +0; like-signed zeros keep their sign
    n_sign = (s1_sub && sum == '0) ? 1'b0 : s1_sign;
  end

  logic          s2_vld, s2_sign, s2_nan, s2_inv, s2_inf;
  logic [XW-1:0] s2_exp;
  logic [SW-1:0] s2_m;

  // S2 register: normalised significand with GRS bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0; s2_sign <= 1'b0; s2_nan <= 1'b0; s2_inv <= 1'b0; s2_inf <= 1'b0;
      s2_exp <= '0;   s2_m <= '0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_sign <= n_sign;
      s2_nan  <= s1_nan;
      s2_inv  <= s1_inv;
      s2_inf  <= s1_inf;
      s2_exp  <= n_e;
      s2_m    <= n_m;
    end
  end

  // ---------------- S3: round, pack, flags ----------------
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] f_frac;
  logic [XW-1:0]    f_e;
  logic             hid, rnd_up, lost, r_inv, r_ovf, r_inx;
  logic [W-1:0]     res;

  // Round to nearest even; a carry into the hidden bit promotes subnormals naturally.
  always_comb begin
    lost   = |s2_m[2:0];
    rnd_up = s2_m[2] & (s2_m[1] | s2_m[0] | s2_m[3]);
    mr     = {1'b0, s2_m[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (mr[MAN_W+1]) begin
      f_frac = mr[MAN_W:1];
      f_e    = s2_exp + XW'(1);
      hid    = 1'b1;
    end else begin
      f_frac = mr[MAN_W-1:0];
      f_e    = s2_exp;
      hid    = mr[MAN_W];
    end
    res   = {s2_sign, (hid ? f_e[EXP_W-1:0] : {EXP_W{1'b0}}), f_frac};
    r_inv = 1'b0;
    r_ovf = 1'b0;
    r_inx = lost;
    if (s2_nan) begin
      res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      r_inv = s2_inv;
      r_inx = 1'b0;
    end else if (s2_inf) begin
      res   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_inx = 1'b0;
    end else if (f_e >= EMAX) begin
      res   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_ovf = 1'b1;
      r_inx = 1'b1;
    end
  end

  // Output register; bubbles present zero data and clear flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      number_out    <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
    end else if (advance) begin
      out_valid     <= s2_vld;
      number_out    <= s2_vld ? res : '0;
      flag_invalid  <= s2_vld & r_inv;
      flag_overflow <= s2_vld & r_ovf;
      flag_inexact  <= s2_vld & r_inx;
    end
  end

endmodule
